// File: rtl/cpu_axi_pkg.sv
// Shared AXI constants and line-fill FSM state type.
// Used by both read-channel line-fill masters.
package cpu_axi_pkg;

  localparam int ID_WIDTH   = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 16;
  localparam int LEN_WIDTH  = 7;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_2B    = 3'b001;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } fill_state_t;

endpackage

// File: rtl/axi_line_fill_if.sv
// AXI4 read-address/read-data channel slice.
// master = line-fill engine, slave = DRAM side.
interface axi_line_fill_if #(
  parameter int ID_WIDTH   = cpu_axi_pkg::ID_WIDTH,
  parameter int ADDR_WIDTH = cpu_axi_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = cpu_axi_pkg::DATA_WIDTH,
  parameter int LEN_WIDTH  = cpu_axi_pkg::LEN_WIDTH
) ();

  logic [ID_WIDTH-1:0]   arid_m_inf;
  logic [ADDR_WIDTH-1:0] araddr_m_inf;
  logic [LEN_WIDTH-1:0]  arlen_m_inf;
  logic [2:0]            arsize_m_inf;
  logic [1:0]            arburst_m_inf;
  logic                  arvalid_m_inf;
  logic                  arready_m_inf;

  logic [ID_WIDTH-1:0]   rid_m_inf;
  logic [DATA_WIDTH-1:0] rdata_m_inf;
  logic [1:0]            rresp_m_inf;
  logic                  rlast_m_inf;
  logic                  rvalid_m_inf;
  logic                  rready_m_inf;

  modport master (
    output arid_m_inf, araddr_m_inf, arlen_m_inf,
    output arsize_m_inf, arburst_m_inf, arvalid_m_inf,
    input  arready_m_inf,
    input  rid_m_inf, rdata_m_inf, rresp_m_inf,
    input  rlast_m_inf, rvalid_m_inf,
    output rready_m_inf
  );

  modport slave (
    input  arid_m_inf, araddr_m_inf, arlen_m_inf,
    input  arsize_m_inf, arburst_m_inf, arvalid_m_inf,
    output arready_m_inf,
    output rid_m_inf, rdata_m_inf, rresp_m_inf,
    output rlast_m_inf, rvalid_m_inf,
    input  rready_m_inf
  );

endinterface

// File: rtl/axi_line_fill.sv
// Cache line fill: one INCR read burst, beats streamed
// into the cache SRAM write port, done/error reported.
module axi_line_fill #(
  parameter int ID_WIDTH   = cpu_axi_pkg::ID_WIDTH,
  parameter int ADDR_WIDTH = cpu_axi_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = cpu_axi_pkg::DATA_WIDTH,
  parameter int LEN_WIDTH  = cpu_axi_pkg::LEN_WIDTH,
  parameter int LINE_WORDS = 128,
  parameter int ARID_VAL   = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fill_req,
  input  logic [ADDR_WIDTH-1:0]         fill_addr,
  output logic                          fill_busy,
  output logic                          fill_done,
  output logic                          fill_err,
  output logic                          wr_en,
  output logic [$clog2(LINE_WORDS)-1:0] wr_idx,
  output logic [DATA_WIDTH-1:0]         wr_data,
  axi_line_fill_if.master               axi
);

  import cpu_axi_pkg::*;

  localparam int IDX_W = $clog2(LINE_WORDS);

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ADDR_WIDTH'(2 * LINE_WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(LINE_WORDS - 1);
  localparam logic [LEN_WIDTH-1:0] BURST_LEN =
    LEN_WIDTH'(LINE_WORDS - 1);
  localparam logic [ID_WIDTH-1:0] ID_VAL =
    ID_WIDTH'(ARID_VAL);

  fill_state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] base;
  logic [IDX_W-1:0]      cnt;
  logic                  err_q;
  logic                  wr_en_q;
  logic [IDX_W-1:0]      wr_idx_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  logic ar_go;
  logic beat;
  logic data_beat;
  logic last_beat;
  logic bad_beat;

  assign ar_go     = axi.arvalid_m_inf && axi.arready_m_inf;
  assign beat      = axi.rvalid_m_inf && axi.rready_m_inf;
  assign data_beat = (state == S_DATA) && beat;
  assign last_beat = (cnt == LAST_IDX);
  assign bad_beat  = (axi.rresp_m_inf != AXI_RESP_OKAY) ||
                     (axi.rid_m_inf != ID_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (fill_req) state_nx = S_ADDR;
      S_ADDR:  if (ar_go) state_nx = S_DATA;
      S_DATA: begin
        if (beat) begin
          if (axi.rlast_m_inf) state_nx = S_FLUSH;
          else if (last_beat)  state_nx = S_DRAIN;
        end
      end
      S_DRAIN: if (beat && axi.rlast_m_inf) state_nx = S_FLUSH;
      S_FLUSH: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // rlast must coincide with the last line word; either mismatch is an error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base      <= '0;
      cnt       <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= data_beat;
      if (data_beat) begin
        wr_idx_q  <= cnt;
        wr_data_q <= axi.rdata_m_inf;
        cnt       <= cnt + 1'b1;
        if (bad_beat || (axi.rlast_m_inf != last_beat))
          err_q <= 1'b1;
      end
      if ((state == S_IDLE) && fill_req) begin
        base  <= fill_addr & ~LINE_MASK;
        cnt   <= '0;
        err_q <= 1'b0;
      end
    end
  end

  assign axi.arvalid_m_inf = (state == S_ADDR);
  assign axi.arid_m_inf    = axi.arvalid_m_inf ? ID_VAL : '0;
  assign axi.araddr_m_inf  = axi.arvalid_m_inf ? base : '0;
  assign axi.arlen_m_inf   = axi.arvalid_m_inf ? BURST_LEN : '0;
  assign axi.arsize_m_inf  = axi.arvalid_m_inf ? AXI_SIZE_2B : '0;
  assign axi.arburst_m_inf = axi.arvalid_m_inf ? AXI_BURST_INCR : '0;
  assign axi.rready_m_inf  = (state == S_DATA) ||
                             (state == S_DRAIN);

  assign fill_busy = (state == S_ADDR)  || (state == S_DATA) ||
                     (state == S_DRAIN) || (state == S_FLUSH);
  assign fill_done = (state == S_DONE);
  assign fill_err  = err_q;
  assign wr_en     = wr_en_q;
  assign wr_idx    = wr_idx_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_axi_line_fill.sv
// Bench for axi_line_fill: vector table, random fills
// against a line-level model, reset-in-burst sequence.
module tb_axi_line_fill;
  import cpu_axi_pkg::*;

  localparam int LW = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fill_req;
  logic [31:0] fill_addr;
  logic        fill_busy, fill_done, fill_err;
  logic        wr_en;
  logic [6:0]  wr_idx;
  logic [15:0] wr_data;

  axi_line_fill_if axi ();

  axi_line_fill #(.LINE_WORDS(LW), .ARID_VAL(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .fill_req(fill_req), .fill_addr(fill_addr),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .fill_err(fill_err), .wr_en(wr_en),
    .wr_idx(wr_idx), .wr_data(wr_data),
    .axi(axi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int ar_delay;
    bit gaps;
    int n_beats;
    int rlast_at;
    int bad_at;
    bit bad_id;
    int exp_writes;
    bit exp_err;
    int exp_cycles;
  } vec_t;

  typedef struct packed {
    logic [6:0]  idx;
    logic [15:0] data;
  } wr_t;

  wr_t         wq[$];
  logic [15:0] bd[0:159];
  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  bit prev_err = 1'b0;
  vec_t tbl[6];

  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (rst_n && wr_en) wq.push_back({wr_idx, wr_data});

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // line-level model: what a fill must write and report
  task automatic model(inout vec_t v);
    int w;
    w = (v.rlast_at < LW) ? v.rlast_at + 1 : LW;
    v.exp_writes = w;
    v.exp_err = (v.rlast_at != LW - 1) ||
                (v.bad_at >= 0 && v.bad_at < w);
    v.exp_cycles = v.ar_delay + v.n_beats +
                   (v.gaps ? v.n_beats / 2 : 0) + 4;
  endtask

  task automatic idle_bus();
    axi.arready_m_inf = 1'b0;
    axi.rvalid_m_inf  = 1'b0;
    axi.rlast_m_inf   = 1'b0;
    axi.rresp_m_inf   = 2'b00;
    axi.rid_m_inf     = 4'h0;
    axi.rdata_m_inf   = 16'h0;
  endtask

  task automatic run_fill(input vec_t v);
    logic [31:0] base;
    int c0;
    int bad_wr;
    base = v.addr & ~32'hFF;
    for (int i = 0; i < 160; i++) bd[i] = 16'($urandom);
    chk("err_hold", fill_err, prev_err);
    wq.delete();
    fill_req = 1'b1;
    fill_addr = v.addr;
    c0 = cyc;
    @(negedge clk);
    fill_req = 1'b0;
    fill_addr = $urandom;
    chk("busy", fill_busy, 1);
    chk("err_clr", fill_err, 0);
    chk("arvalid", axi.arvalid_m_inf, 1);
    chk("araddr", axi.araddr_m_inf, base);
    chk("arlen", axi.arlen_m_inf, LW - 1);
    chk("arsize", axi.arsize_m_inf, 1);
    chk("arburst", axi.arburst_m_inf, 1);
    chk("arid", axi.arid_m_inf, 0);
    for (int i = 0; i < v.ar_delay; i++) begin
      @(negedge clk);
      chk("ar_hold_v", axi.arvalid_m_inf, 1);
      chk("ar_hold_a", axi.araddr_m_inf, base);
    end
    axi.arready_m_inf = 1'b1;
    @(negedge clk);
    axi.arready_m_inf = 1'b0;
    chk("ar_drop", axi.arvalid_m_inf, 0);
    for (int b = 0; b < v.n_beats; b++) begin
      if (v.gaps && (b % 2 == 1)) begin
        axi.rvalid_m_inf = 1'b0;
        @(negedge clk);
      end
      axi.rvalid_m_inf = 1'b1;
      axi.rdata_m_inf  = bd[b];
      axi.rid_m_inf    = (v.bad_id && b == v.bad_at) ? 4'h3 : 4'h0;
      axi.rresp_m_inf  = (!v.bad_id && b == v.bad_at) ? 2'b10 : 2'b00;
      axi.rlast_m_inf  = (b == v.rlast_at);
      chk("rready", axi.rready_m_inf, 1);
      @(negedge clk);
    end
    idle_bus();
    chk("flush_nodone", fill_done, 0);
    chk("flush_busy", fill_busy, 1);
    @(negedge clk);
    chk("done", fill_done, 1);
    chk("done_busy", fill_busy, 0);
    chk("fill_err", fill_err, v.exp_err);
    chk("latency", cyc - c0 + 1, v.exp_cycles);
    chk("n_writes", wq.size(), v.exp_writes);
    bad_wr = 0;
    foreach (wq[k])
      if (wq[k].idx !== 7'(k) || wq[k].data !== bd[k]) bad_wr++;
    chk("wr_content", bad_wr, 0);
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
    chk("done_ign_req", fill_busy, 0);
    chk("idle_no_ar", axi.arvalid_m_inf, 0);
    prev_err = v.exp_err;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int kind;
    rst_n = 1'b0;
    fill_req = 1'b0;
    fill_addr = '0;
    idle_bus();
    tbl[0] = '{32'h0000_1234, 0, 0, 128, 127, -1, 0, 128, 0, 132};
    tbl[1] = '{32'h0000_ABCD, 5, 1, 128, 127, -1, 0, 128, 0, 201};
    tbl[2] = '{32'h2000_0010, 0, 0, 10, 9, -1, 0, 10, 1, 14};
    tbl[3] = '{32'h0000_03FF, 1, 0, 130, 129, -1, 0, 128, 1, 135};
    tbl[4] = '{32'h0000_4000, 0, 0, 128, 127, 5, 0, 128, 1, 132};
    tbl[5] = '{32'h0000_5500, 2, 1, 128, 127, 20, 1, 128, 1, 198};
    repeat (3) @(negedge clk);
    chk("rst_busy", fill_busy, 0);
    chk("rst_done", fill_done, 0);
    chk("rst_err", fill_err, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_arvalid", axi.arvalid_m_inf, 0);
    chk("rst_rready", axi.rready_m_inf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 6; t++) run_fill(tbl[t]);

    for (int r = 0; r < 8; r++) begin
      v.addr = $urandom;
      v.ar_delay = $urandom_range(0, 3);
      v.gaps = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        v.n_beats = LW;
        v.rlast_at = LW - 1;
      end else if (kind == 1) begin
        v.rlast_at = $urandom_range(0, LW - 2);
        v.n_beats = v.rlast_at + 1;
      end else begin
        v.n_beats = $urandom_range(LW + 1, LW + 3);
        v.rlast_at = v.n_beats - 1;
      end
      v.bad_at = ($urandom_range(0, 2) == 0) ?
                 int'($urandom_range(0, v.n_beats - 1)) : -1;
      v.bad_id = 1'($urandom_range(0, 1));
      model(v);
      run_fill(v);
    end

    fill_req = 1'b1;
    fill_addr = 32'h0000_7777;
    @(negedge clk);
    fill_req = 1'b0;
    axi.arready_m_inf = 1'b1;
    @(negedge clk);
    axi.arready_m_inf = 1'b0;
    for (int b = 0; b < 40; b++) begin
      axi.rvalid_m_inf = 1'b1;
      axi.rdata_m_inf = 16'(b);
      @(negedge clk);
    end
    chk("pre_rst_wr_en", wr_en, 1);
    chk("pre_rst_rready", axi.rready_m_inf, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_arvalid", axi.arvalid_m_inf, 0);
    chk("arst_rready", axi.rready_m_inf, 0);
    chk("arst_wr_en", wr_en, 0);
    chk("arst_busy", fill_busy, 0);
    idle_bus();
    @(negedge clk);
    rst_n = 1'b1;
    prev_err = 1'b0;
    @(negedge clk);
    run_fill(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
